// File: rtl/checkpoint_seq_pkg.sv
// Shared types and helpers for the checkpoint sequence monitor.
// Index width is derived here so the top and the table agree on address sizes.
package checkpoint_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StPass,
        StFail
    } state_e;

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/checkpoint_seq_table.sv
// Expected-value/mask table: DEPTH entries of {mask, data}, one synchronous write port
// and one combinational read port.
module checkpoint_seq_table
    import checkpoint_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [idx_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [WIDTH-1:0]        wmask,
    input  logic [idx_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata,
    output logic [WIDTH-1:0]        rmask
);

    logic [2*WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= {wmask, wdata};
        end
    end

    assign rdata = mem_q[raddr][WIDTH-1:0];
    assign rmask = mem_q[raddr][2*WIDTH-1:WIDTH];

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Ordered checkpoint monitor: walks a programmed table of masked expected values against a
// registered observation bus, with glitch filter, per-step timeout and sticky verdict.
module checkpoint_seq_monitor
    import checkpoint_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned STABLE = 1,
    parameter int unsigned TMR_W  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        obs,
    input  logic                    prog_we,
    input  logic [idx_w(DEPTH)-1:0] prog_addr,
    input  logic [WIDTH-1:0]        prog_data,
    input  logic [WIDTH-1:0]        prog_mask,
    input  logic [idx_w(DEPTH):0]   seq_len,
    input  logic [TMR_W-1:0]        timeout_cycles,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    step_match,
    output logic [idx_w(DEPTH)-1:0] step_idx,
    output logic                    done,
    output logic                    pass,
    output logic [idx_w(DEPTH)-1:0] fail_idx
);

    localparam int unsigned IW = idx_w(DEPTH);
    localparam int unsigned LW = IW + 1;
    localparam int unsigned SW = $clog2(STABLE + 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [SW-1:0]     stable_q, stable_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [LW-1:0]     len_q, len_d;
    logic [TMR_W-1:0]  tmo_q, tmo_d;
    logic [WIDTH-1:0]  obs_q;
    logic              acc_q, acc_d;
    logic [IW-1:0]     acc_idx_q, acc_idx_d;
    logic [IW-1:0]     err_idx_q, err_idx_d;

    logic              busy_q, busy_d;
    logic              step_match_q, step_match_d;
    logic [IW-1:0]     step_idx_q, step_idx_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [IW-1:0]     fail_idx_q, fail_idx_d;

    logic [WIDTH-1:0]  exp_rd, mask_rd;
    logic              hit, accept, last_step, timeout_hit;

    checkpoint_seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
        .clock (clock),
        .we    (prog_we && (state_q != StWait)),
        .waddr (prog_addr),
        .wdata (prog_data),
        .wmask (prog_mask),
        .raddr (idx_q),
        .rdata (exp_rd),
        .rmask (mask_rd)
    );

    assign hit         = ((obs_q ^ exp_rd) & mask_rd) == '0;
    assign accept      = (state_q == StWait) && hit && (stable_q == SW'(STABLE - 1));
    assign last_step   = ({1'b0, idx_q} == (len_q - LW'(1)));
    assign timeout_hit = (tmo_q != '0) && (timer_q == (tmo_q - TMR_W'(1)));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stable_d  = stable_q;
        timer_d   = timer_q;
        len_d     = len_q;
        tmo_d     = tmo_q;
        acc_d     = 1'b0;
        acc_idx_d = idx_q;
        err_idx_d = err_idx_q;
        if (abort) begin
            state_d   = StIdle;
            idx_d     = '0;
            stable_d  = '0;
            timer_d   = '0;
            err_idx_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StPass, StFail: begin
                    if (start) begin
                        // Lengths beyond the table would never reach the final index.
                        len_d     = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
                        tmo_d     = timeout_cycles;
                        idx_d     = '0;
                        stable_d  = '0;
                        timer_d   = '0;
                        err_idx_d = '0;
                        state_d   = (seq_len == '0) ? StPass : StWait;
                    end
                end
                StWait: begin
                    timer_d  = timer_q + TMR_W'(1);
                    stable_d = hit ? (stable_q + SW'(1)) : '0;
                    if (accept) begin
                        acc_d    = 1'b1;
                        idx_d    = idx_q + IW'(1);
                        stable_d = '0;
                        timer_d  = '0;
                        if (last_step) begin
                            state_d = StPass;
                        end
                    end else if (timeout_hit) begin
                        state_d   = StFail;
                        err_idx_d = idx_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy_d       = (state_q == StWait);
        step_match_d = acc_q;
        step_idx_d   = acc_q ? acc_idx_q : step_idx_q;
        done_d       = (state_q == StPass) || (state_q == StFail);
        pass_d       = (state_q == StPass);
        fail_idx_d   = (state_q == StFail) ? err_idx_q : '0;
        // Re-arming drops the old verdict on the same edge that accepts start.
        if (abort || (start && (state_q != StWait))) begin
            done_d     = 1'b0;
            pass_d     = 1'b0;
            fail_idx_d = '0;
        end
        if (abort) begin
            busy_d       = 1'b0;
            step_match_d = 1'b0;
            step_idx_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            stable_q     <= '0;
            timer_q      <= '0;
            len_q        <= '0;
            tmo_q        <= '0;
            obs_q        <= '0;
            acc_q        <= 1'b0;
            acc_idx_q    <= '0;
            err_idx_q    <= '0;
            busy_q       <= 1'b0;
            step_match_q <= 1'b0;
            step_idx_q   <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            stable_q     <= stable_d;
            timer_q      <= timer_d;
            len_q        <= len_d;
            tmo_q        <= tmo_d;
            obs_q        <= obs;
            acc_q        <= acc_d;
            acc_idx_q    <= acc_idx_d;
            err_idx_q    <= err_idx_d;
            busy_q       <= busy_d;
            step_match_q <= step_match_d;
            step_idx_q   <= step_idx_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    assign busy       = busy_q;
    assign step_match = step_match_q;
    assign step_idx   = step_idx_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: two instances (STABLE=1 and STABLE=4) share stimulus; each
// run is recorded and compared against a window-search model of the step sequence.
module tb_checkpoint_seq_monitor;

    localparam int NMAX = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] obs;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [15:0] prog_mask;
    logic [5:0]  seq_len;
    logic [31:0] timeout_cycles;
    logic        start;
    logic        abort;

    logic        a_busy, a_step_match, a_done, a_pass;
    logic [4:0]  a_step_idx, a_fail_idx;
    logic        b_busy, b_step_match, b_done, b_pass;
    logic [4:0]  b_step_idx, b_fail_idx;

    int errors = 0;
    int checks = 0;

    // Reference configuration and recorded run
    logic [15:0] m_exp  [32];
    logic [15:0] m_mask [32];
    int          m_len, m_tmo, m_stable, dut_sel;
    int          inj_k;
    logic [4:0]  inj_addr;
    logic [15:0] inj_data;
    logic [15:0] pat    [NMAX];
    logic        r_sm   [NMAX];
    logic [4:0]  r_idx  [NMAX];
    logic        r_done [NMAX];
    logic        r_pass [NMAX];
    logic        r_busy [NMAX];
    logic [4:0]  r_fidx [NMAX];

    always #5 clock = ~clock;

    checkpoint_seq_monitor #(.WIDTH(16), .DEPTH(32), .STABLE(1), .TMR_W(32)) dut_a (
        .clock(clock), .reset(reset), .obs(obs), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_mask(prog_mask), .seq_len(seq_len),
        .timeout_cycles(timeout_cycles), .start(start), .abort(abort), .busy(a_busy),
        .step_match(a_step_match), .step_idx(a_step_idx), .done(a_done), .pass(a_pass),
        .fail_idx(a_fail_idx)
    );

    checkpoint_seq_monitor #(.WIDTH(16), .DEPTH(32), .STABLE(4), .TMR_W(32)) dut_b (
        .clock(clock), .reset(reset), .obs(obs), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_mask(prog_mask), .seq_len(seq_len),
        .timeout_cycles(timeout_cycles), .start(start), .abort(abort), .busy(b_busy),
        .step_match(b_step_match), .step_idx(b_step_idx), .done(b_done), .pass(b_pass),
        .fail_idx(b_fail_idx)
    );

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            start = 1'b0; abort = 1'b0; prog_we = 1'b0;
        end
    endtask

    task automatic prepare();
        @(posedge clock); #1;
        abort = 1'b1; start = 1'b0; prog_we = 1'b0;
        inj_k = -1;
    endtask

    task automatic prog(input int a, input logic [15:0] d, input logic [15:0] m);
        @(posedge clock); #1;
        abort = 1'b0; start = 1'b0; prog_we = 1'b1;
        prog_addr = 5'(a); prog_data = d; prog_mask = m;
        m_exp[a] = d; m_mask[a] = m;
    endtask

    task automatic configure(input int sel, input int len, input int tmo);
        dut_sel = sel; m_stable = (sel != 0) ? 4 : 1;
        m_len = len; m_tmo = tmo;
        seq_len = 6'(len); timeout_cycles = 32'(tmo);
    endtask

    // Period k: inputs driven after posedge k, outputs sampled on the following negedge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            abort = 1'b0;
            obs   = pat[k];
            start = (k == 0);
            if (k == inj_k) begin
                prog_we = 1'b1; prog_addr = inj_addr; prog_data = inj_data; prog_mask = 16'hFFFF;
            end else begin
                prog_we = 1'b0;
            end
            @(negedge clock);
            if (dut_sel == 0) begin
                r_sm[k] = a_step_match; r_idx[k] = a_step_idx; r_done[k] = a_done;
                r_pass[k] = a_pass; r_busy[k] = a_busy; r_fidx[k] = a_fail_idx;
            end else begin
                r_sm[k] = b_step_match; r_idx[k] = b_step_idx; r_done[k] = b_done;
                r_pass[k] = b_pass; r_busy[k] = b_busy; r_fidx[k] = b_fail_idx;
            end
        end
        @(posedge clock); #1;
        start = 1'b0; prog_we = 1'b0;
    endtask

    // Each step searches obs from the period after the previous acceptance for STABLE
    // consecutive hits; results surface three periods after the last hit sample.
    task automatic check_run(input string name, input int n);
        logic e_sm [NMAX];
        int   e_idx [NMAX];
        int   first, run_len, ulast, ulim, vk, fidx;
        bit   vpass, found, stop, e_done, e_pass, e_busy;
        for (int k = 0; k < NMAX; k++) begin
            e_sm[k] = 1'b0; e_idx[k] = 0;
        end
        vk = -1; vpass = 0; fidx = 0; first = 0; stop = 0; ulast = 0;
        if (m_len == 0) begin
            vk = 2; vpass = 1;
        end else begin
            for (int j = 0; j < m_len && !stop; j++) begin
                found = 0; run_len = 0;
                ulim = n;
                if (m_tmo != 0 && first + m_tmo < n) ulim = first + m_tmo;
                for (int u = first; u < ulim && !found; u++) begin
                    if (((pat[u] ^ m_exp[j]) & m_mask[j]) == 16'h0) run_len++;
                    else run_len = 0;
                    if (run_len == m_stable) begin found = 1; ulast = u; end
                end
                if (found) begin
                    if (ulast + 3 < NMAX) begin e_sm[ulast+3] = 1'b1; e_idx[ulast+3] = j; end
                    first = ulast + 1;
                    if (j == m_len - 1) begin vk = ulast + 3; vpass = 1; end
                end else begin
                    stop = 1;
                    if (m_tmo != 0) begin vk = first + m_tmo + 2; vpass = 0; fidx = j; end
                end
            end
        end
        for (int k = 0; k < n; k++) begin
            e_done = (vk >= 0) && (k >= vk);
            e_pass = e_done && vpass;
            e_busy = (m_len != 0) && (k >= 2) && ((vk < 0) || (k < vk));
            checks++;
            if (r_sm[k] !== e_sm[k]) begin
                errors++;
                $display("FAIL %s step_match k=%0d got=%0b exp=%0b", name, k, r_sm[k], e_sm[k]);
            end
            if (e_sm[k]) begin
                checks++;
                if (r_idx[k] !== 5'(e_idx[k])) begin
                    errors++;
                    $display("FAIL %s step_idx k=%0d got=%0d exp=%0d", name, k, r_idx[k], e_idx[k]);
                end
            end
            checks++;
            if (r_done[k] !== e_done) begin
                errors++;
                $display("FAIL %s done k=%0d got=%0b exp=%0b", name, k, r_done[k], e_done);
            end
            checks++;
            if (r_pass[k] !== e_pass) begin
                errors++;
                $display("FAIL %s pass k=%0d got=%0b exp=%0b", name, k, r_pass[k], e_pass);
            end
            checks++;
            if (r_busy[k] !== e_busy) begin
                errors++;
                $display("FAIL %s busy k=%0d got=%0b exp=%0b", name, k, r_busy[k], e_busy);
            end
            if (e_done && !vpass) begin
                checks++;
                if (r_fidx[k] !== 5'(fidx)) begin
                    errors++;
                    $display("FAIL %s fail_idx k=%0d got=%0d exp=%0d", name, k, r_fidx[k], fidx);
                end
            end
        end
    endtask

    task automatic fill(input int from, input int to, input logic [15:0] v);
        for (int k = from; k < to; k++) pat[k] = v;
    endtask

    task automatic test_reset();
        reset = 1'b1; obs = 16'hBEEF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({a_busy, a_step_match, a_step_idx, a_done, a_pass, a_fail_idx} !== 14'h0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=0",
                     {a_busy, a_step_match, a_step_idx, a_done, a_pass, a_fail_idx});
        end
        checks++;
        if ({b_busy, b_step_match, b_step_idx, b_done, b_pass, b_fail_idx} !== 14'h0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=0",
                     {b_busy, b_step_match, b_step_idx, b_done, b_pass, b_fail_idx});
        end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({a_busy, a_done, a_pass, b_busy, b_done, b_pass} !== 6'h0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=0",
                     {a_busy, a_done, a_pass, b_busy, b_done, b_pass});
        end
    endtask

    task automatic test_sequence();
        prepare();
        prog(0, 16'h003E, 16'hFFFF); prog(1, 16'h0044, 16'hFFFF);
        prog(2, 16'h004A, 16'hFFFF); prog(3, 16'h0050, 16'hFFFF);
        idle_cycles(1);
        configure(0, 4, 0);
        fill(0, 10, 16'h003E); fill(10, 20, 16'h0044);
        fill(20, 30, 16'h004A); fill(30, 50, 16'h0050);
        run(50);
        check_run("sequence", 50);
    endtask

    task automatic test_glitch();
        prepare();
        prog(0, 16'h0044, 16'hFFFF);
        idle_cycles(1);
        configure(1, 1, 0);
        fill(0, 30, 16'h0000); fill(3, 5, 16'h0044); fill(6, 11, 16'h0044);
        run(30);
        check_run("glitch_stable4", 30);
    endtask

    task automatic test_timeout();
        prepare();
        prog(0, 16'h0011, 16'hFFFF); prog(1, 16'h0022, 16'hFFFF);
        idle_cycles(1);
        configure(0, 2, 100);
        fill(0, 110, 16'h0099); fill(0, 3, 16'h0011);
        run(110);
        check_run("timeout", 110);
    endtask

    task automatic test_mask();
        prepare();
        prog(0, 16'hAB00, 16'hFF00);
        idle_cycles(1);
        configure(0, 1, 0);
        fill(0, 5, 16'hAC40); fill(5, 16, 16'hAB40);
        run(16);
        check_run("mask", 16);
    endtask

    task automatic test_zero_len();
        prepare();
        idle_cycles(1);
        configure(0, 0, 0);
        fill(0, 8, 16'h0000);
        run(8);
        check_run("zero_len", 8);
    endtask

    task automatic test_abort();
        prepare();
        prog(0, 16'h0001, 16'hFFFF); prog(1, 16'h0002, 16'hFFFF);
        prog(2, 16'h0003, 16'hFFFF); prog(3, 16'h0004, 16'hFFFF);
        idle_cycles(1);
        configure(0, 4, 0);
        fill(0, 8, 16'h7777); fill(0, 1, 16'h0001);
        run(8);
        check_run("pre_abort", 8);
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        checks++;
        if ({a_busy, a_step_match, a_step_idx, a_done, a_pass, a_fail_idx} !== 14'h0) begin
            errors++;
            $display("FAIL abort_clear got=%h exp=0",
                     {a_busy, a_step_match, a_step_idx, a_done, a_pass, a_fail_idx});
        end
        @(posedge clock); #1;
        abort = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0; start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({a_busy, a_done, b_busy, b_done} !== 4'h0) begin
            errors++;
            $display("FAIL abort_over_start got=%b exp=0", {a_busy, a_done, b_busy, b_done});
        end
        prepare();
        idle_cycles(1);
        fill(0, 5, 16'h0001); fill(5, 10, 16'h0002);
        fill(10, 15, 16'h0003); fill(15, 30, 16'h0004);
        run(30);
        check_run("restart", 30);
    endtask

    task automatic test_back_to_back();
        prepare();
        prog(0, 16'd539, 16'hFFFF); prog(1, 16'd732, 16'hFFFF); prog(2, 16'd539, 16'hFFFF);
        idle_cycles(1);
        configure(0, 3, 0);
        fill(0, 10, 16'd539); fill(10, 20, 16'd732); fill(20, 36, 16'd539);
        // Write attempt while busy must not retarget step 1 onto the held value.
        inj_k = 4; inj_addr = 5'd1; inj_data = 16'd539;
        run(36);
        check_run("back_to_back", 36);
    endtask

    task automatic test_random();
        int hold, e, len, tmo;
        logic [15:0] v, m;
        v = 16'h0;
        for (int it = 0; it < 8; it++) begin
            prepare();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       m = 16'h0000;
                    1:       m = 16'h00FF;
                    default: m = 16'hFFFF;
                endcase
                prog(i, 16'($urandom), m);
            end
            idle_cycles(1);
            tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(6, 40));
            configure(int'($urandom_range(0, 1)), len, tmo);
            hold = 0;
            for (int k = 0; k < 150; k++) begin
                if (hold == 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        v = 16'($urandom);
                    end else begin
                        e = $urandom_range(0, len - 1);
                        v = (m_exp[e] & m_mask[e]) | (16'($urandom) & ~m_mask[e]);
                    end
                    hold = $urandom_range(1, 8);
                end
                pat[k] = v;
                hold--;
            end
            run(150);
            check_run($sformatf("random%0d", it), 150);
        end
    endtask

    initial begin
        reset = 1'b1; obs = 16'h0; prog_we = 1'b0; prog_addr = 5'h0; prog_data = 16'h0;
        prog_mask = 16'h0; seq_len = 6'h0; timeout_cycles = 32'h0; start = 1'b0; abort = 1'b0;
        inj_k = -1; inj_addr = 5'h0; inj_data = 16'h0;
        m_len = 0; m_tmo = 0; m_stable = 1; dut_sel = 0;
        test_reset();
        test_sequence();
        test_glitch();
        test_timeout();
        test_mask();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
